// File: rtl/load_store_unit_rv32i.sv
// RV32I load/store unit: one word-wide bus transaction per request with lane alignment and load
// extension. Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit_rv32i #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        data_r,
    input  logic        data_w,
    input  logic [1:0]  data_size,
    input  logic        unsigned_value,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             store_q;
    logic             fail_q;
    logic [31:0]      word_q;

    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        misalign;
    logic        timeout_hit;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (data_size == 2'b01 && addr[0]) || (data_size[1] && addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // ACK_TIMEOUT of zero disables the abort entirely
    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt == CNT_LAST);

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = wdata;
        case (data_size)
            2'b00: begin
                be_n    = 4'b0001 << addr[1:0];
                wdata_n = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_n    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = 8'(word_q >> {off_q, 3'b000});
        half_sel = off_q[1] ? word_q[31:16] : word_q[15:0];
        case (size_q)
            2'b00:   ext = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ext = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ext = word_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            store_q   <= 1'b0;
            fail_q    <= 1'b0;
            word_q    <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'h0;
            bus_wdata <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (data_r || data_w) begin
                            off_q     <= addr[1:0];
                            size_q    <= data_size;
                            uns_q     <= unsigned_value;
                            store_q   <= data_w;
                            cnt       <= '0;
                            busy      <= 1'b1;
                            bus_we    <= data_w;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be_n;
                            bus_wdata <= wdata_n;
                            fail_q    <= misalign;
                            bus_req   <= !misalign;
                            state     <= misalign ? RESP : REQ;
                        end else begin
                            // Neither load nor store: complete immediately with no bus traffic
                            done  <= 1'b1;
                            err   <= 1'b0;
                            rdata <= 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        word_q  <= bus_rdata;
                        bus_req <= 1'b0;
                        state   <= RESP;
                    end else if (timeout_hit) begin
                        bus_req <= 1'b0;
                        fail_q  <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    done  <= 1'b1;
                    err   <= fail_q;
                    rdata <= (fail_q || store_q) ? 32'h0 : ext;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit_rv32i.sv
// Scoreboard bench for load_store_unit_rv32i: stimulus pushes expected bus requests and responses,
// a negedge monitor pops and compares them; a bus agent answers requests with a programmed delay.
module tb_load_store_unit_rv32i;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        data_r = 1'b0;
    logic        data_w = 1'b0;
    logic [1:0]  data_size = 2'b00;
    logic        unsigned_value = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    always #5 clk = ~clk;

    load_store_unit_rv32i dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_r(data_r), .data_w(data_w),
        .data_size(data_size), .unsigned_value(unsigned_value), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic        err;
        logic        chk_rdata;
        logic [31:0] rdata;
        int          req_cycles;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus agent: acks after ack_delay request cycles unless no_ack is set
    int          ack_delay = 1;
    bit          no_ack = 1'b0;
    logic [31:0] next_rdata = 32'h0;
    int          agent_cnt = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (bus_req && !bus_ack) begin
            agent_cnt++;
            if (!no_ack && agent_cnt >= ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = next_rdata;
            end
        end else begin
            bus_ack   = 1'b0;
            agent_cnt = 0;
            bus_rdata = $urandom;
        end
    end

    // Monitor
    logic prev_req = 1'b0;
    int   req_cycles = 0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_req   = 1'b0;
            req_cycles = 0;
        end else begin
            if (bus_req) begin
                if (!prev_req) begin
                    req_cycles = 0;
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bus_req: got request at addr %h expected none",
                                 bus_addr);
                    end else begin
                        bus_exp_t b;
                        b = bus_q.pop_front();
                        check("bus_addr", bus_addr, b.addr);
                        check("bus_we", 32'(bus_we), 32'(b.we));
                        check("bus_be", 32'(bus_be), 32'(b.be));
                        if (b.we) check("bus_wdata", bus_wdata, b.wdata);
                    end
                end
                req_cycles++;
            end
            prev_req = bus_req;
            if (done) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    resp_exp_t e;
                    e = resp_q.pop_front();
                    check("err", 32'(err), 32'(e.err));
                    if (e.chk_rdata) check("rdata", rdata, e.rdata);
                    check("req_cycles", 32'(req_cycles), 32'(e.req_cycles));
                    check("busy_at_done", 32'(busy), 32'h0);
                end
                req_cycles = 0;
            end
        end
    end

    // Reference model built from access width and lane arithmetic
    function automatic void model(input logic r, input logic w, input logic [1:0] sz,
                                  input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd, input int dly, input bit noack,
                                  output bit has_bus, output bus_exp_t b, output resp_exp_t e);
        int nbytes, lane;
        logic [31:0] mask, val;
        bit mis;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        lane   = (nbytes == 4) ? 0 : (nbytes == 2) ? int'(a[1]) * 2 : int'(a[1:0]);
        mis    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (int'(a[1:0]) % nbytes) != 0;
`endif
        b = '0;
        e.err = 1'b0; e.chk_rdata = 1'b1; e.rdata = 32'h0; e.req_cycles = 0;
        has_bus = 1'b0;
        if (!r && !w) begin
            e.chk_rdata = 1'b0;
            return;
        end
        if (mis) begin
            e.err = 1'b1;
            return;
        end
        has_bus = 1'b1;
        b.addr  = a & 32'hFFFF_FFFC;
        b.we    = w;
        b.be    = 4'(((1 << nbytes) - 1) << lane);
        for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        if (noack) begin
            e.err = 1'b1;
            e.req_cycles = 16;
        end else begin
            e.req_cycles = dly;
            if (!w) begin
                mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nbytes)) - 32'h1;
                val  = (rd >> (8 * lane)) & mask;
                if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
                e.rdata = val;
            end
        end
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (resp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (resp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
            resp_q.delete();
            bus_q.delete();
        end
    endtask

    // Called at posedge+1; start is sampled on the following edge
    task automatic issue(input logic r, input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int dly, input bit noack, input bit wait_end);
        bit hb;
        bus_exp_t b;
        resp_exp_t e;
        model(r, w, sz, uns, a, wd, rd, dly, noack, hb, b, e);
        ack_delay  = dly;
        no_ack     = noack;
        next_rdata = rd;
        if (hb) bus_q.push_back(b);
        resp_q.push_back(e);
        data_r = r; data_w = w; data_size = sz; unsigned_value = uns; addr = a; wdata = wd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        data_r = 1'($urandom); data_w = 1'($urandom); data_size = 2'($urandom);
        unsigned_value = 1'($urandom); addr = $urandom; wdata = $urandom;
        if (wait_end) wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_bus_we", 32'(bus_we), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 0, 1);        // LW
        issue(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF_FF7F, 1, 0, 1);        // LB
        issue(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF_FF7F, 3, 0, 1);        // LBU
        issue(1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h80FF_FF7F, 1, 0, 1);        // LHU
        issue(1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h80FF_FF7F, 2, 0, 1);        // LH
        issue(0, 1, 2'b00, 0, 32'h101, 32'h1234_5678, 32'h0, 1, 0, 1);        // SB
        issue(0, 1, 2'b01, 0, 32'h102, 32'h1234_5678, 32'h0, 2, 0, 1);        // SH
        issue(1, 0, 2'b10, 0, 32'h102, 32'h0, 32'hCAFE_F00D, 1, 0, 1);        // misaligned LW
        issue(1, 1, 2'b10, 0, 32'h204, 32'hA5A5_5A5A, 32'h1111_2222, 1, 0, 1); // r&w -> store
        issue(0, 0, 2'b10, 0, 32'h208, 32'h0, 32'h0, 1, 0, 1);                // no-op start
        issue(1, 0, 2'b11, 1, 32'h20C, 32'h0, 32'h8765_4321, 1, 0, 1);        // size 11 = word
        issue(1, 0, 2'b10, 0, 32'h210, 32'h0, 32'h0BAD_CAFE, 16, 0, 1);       // ack on last cycle
        issue(1, 0, 2'b10, 0, 32'h214, 32'h0, 32'h0, 1, 1, 1);                // timeout
        issue(1, 0, 2'b10, 0, 32'h218, 32'h0, 32'h1357_9BDF, 1, 0, 1);        // recovers

        // start while busy is ignored
        issue(1, 0, 2'b10, 0, 32'h400, 32'h0, 32'h2468_ACE0, 6, 0, 0);
        @(posedge clk);
        #1;
        start = 1'b1; data_r = 1'b1; data_w = 1'b1; addr = 32'h500;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // async reset in REQ aborts with no done
        issue(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h0, 1, 1, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_bus_req", 32'(bus_req), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        resp_q.delete();
        bus_q.delete();
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        issue(1, 0, 2'b00, 0, 32'h301, 32'h0, 32'h0000_8000, 2, 0, 1);

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                  $urandom, int'($urandom_range(1, 4)), 0, 1);
        end

        repeat (3) @(posedge clk);
        check("leftover_bus", 32'(bus_q.size()), 32'h0);
        check("leftover_resp", 32'(resp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
